// File: rtl/clock_divider_ring_counter_ssd_if.sv
// Display-side signals of the four-digit seven-segment scanner.
// The controller drives H/L/digit; whoever owns the value drives Num.
interface clock_divider_ring_counter_ssd_if;
  logic [15:0] Num;
  logic [3:0]  H;
  logic [6:0]  L;
  logic [1:0]  digit;

  modport master (output Num, input H, L, digit);
  modport slave  (input Num, output H, L, digit);
endinterface

// File: rtl/clock_divider_ring_counter_ssd.sv
// Multiplexed four-digit hex display driver.
// A divider enables a 2-bit ring index; anode and segment lines are registered every clk.
module clock_divider_ring_counter_ssd #(
  parameter int SCAN_DIV = 200000
) (
  input  logic clk,
  input  logic rst_n,
  clock_divider_ring_counter_ssd_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       h_q, h_d;
  logic [6:0]       l_q, l_d;
  logic [3:0]       nibble;
  logic             scan_tick;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // H/L follow the pre-edge index, so they trail a digit change by one clk.
  always_comb begin
    scan_tick = (cnt_q == CNT_MAX);
    cnt_d     = scan_tick ? '0 : cnt_q + CNT_W'(1);
    digit_d   = scan_tick ? digit_q + 2'd1 : digit_q;
    h_d       = 4'b0111;
    nibble    = bus.Num[15:12];
    case (digit_q)
      2'd0: begin h_d = 4'b0111; nibble = bus.Num[15:12]; end
      2'd1: begin h_d = 4'b1011; nibble = bus.Num[11:8];  end
      2'd2: begin h_d = 4'b1101; nibble = bus.Num[7:4];   end
      default: begin h_d = 4'b1110; nibble = bus.Num[3:0]; end
    endcase
    l_d = hex_to_seg(nibble);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      digit_q <= 2'd0;
      h_q     <= 4'b1111;
      l_q     <= 7'b1111111;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      h_q     <= h_d;
      l_q     <= l_d;
    end
  end

  assign bus.H     = h_q;
  assign bus.L     = l_q;
  assign bus.digit = digit_q;

endmodule

// File: tb/tb_clock_divider_ring_counter_ssd.sv
// Directed bench for the seven-segment scanner at SCAN_DIV=4, plus a SCAN_DIV=1 instance.
module tb_clock_divider_ring_counter_ssd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  int   k = 0;

  always #5 clk = ~clk;

  clock_divider_ring_counter_ssd_if bus ();
  clock_divider_ring_counter_ssd_if bus1 ();

  clock_divider_ring_counter_ssd #(.SCAN_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  clock_divider_ring_counter_ssd #(.SCAN_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  logic [3:0] h_tab [4]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] l_dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Edge k counts rising edges since the last reset release.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic int shown(input int e);
    return ((e - 1) / 4) % 4;
  endfunction

  function automatic int dig(input int e);
    return (e / 4) % 4;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] n, input int idx);
    return n[15 - 4*idx -: 4];
  endfunction

  task automatic check_edge(input string tag);
    chk({tag, "_digit"}, 16'(bus.digit), 16'(dig(k)));
    chk({tag, "_h"}, 16'(bus.H), 16'(h_tab[shown(k)]));
    chk({tag, "_l"}, 16'(bus.L), 16'(l_dec[nib(bus.Num, shown(k))]));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int guard;
    bus.Num  = 16'h1234;
    bus1.Num = 16'h1234;
    rst_n    = 1'b0;
    step();
    step();
    chk("rst_h", 16'(bus.H), 16'hF);
    chk("rst_l", 16'(bus.L), 16'h7F);
    chk("rst_digit", 16'(bus.digit), 16'h0);
    chk("rst_h_div1", 16'(bus1.H), 16'hF);

    rst_n = 1'b1;
    k = 0;
    step();
    chk("first_h", 16'(bus.H), 16'b0111);
    chk("first_l", 16'(bus.L), 16'b1111001);
    chk("div1_digit", 16'(bus1.digit), 16'(k % 4));
    for (int i = 0; i < 16; i++) begin
      step();
      check_edge("scan");
      chk("div1_digit", 16'(bus1.digit), 16'(k % 4));
      chk("div1_h", 16'(bus1.H), 16'(h_tab[(k - 1) % 4]));
    end

    n = 0;
    guard = 0;
    while (n < 16 && guard < 200) begin
      guard++;
      if (shown(k + 1) == 3) begin
        bus.Num = {12'h123, 4'(n)};
        step();
        chk("decode_l", 16'(bus.L), 16'(l_dec[n]));
        chk("decode_h", 16'(bus.H), 16'b1110);
        n++;
      end else begin
        step();
      end
    end
    if (n < 16) chk("decode_timeout", 16'(n), 16'd16);

    guard = 0;
    while ((k + 1) % 16 != 5 && guard < 40) begin
      step();
      guard++;
    end
    bus.Num = 16'h0000;
    step();
    chk("live_l0", 16'(bus.L), 16'h40);
    bus.Num = 16'h0A00;
    step();
    chk("live_l", 16'(bus.L), 16'b0001000);
    chk("live_h", 16'(bus.H), 16'b1011);
    chk("live_digit", 16'(bus.digit), 16'd1);

    // Reset lands on a tick edge during digit 2, so it must beat the advance.
    guard = 0;
    while ((k + 1) % 16 != 12 && guard < 40) begin
      step();
      guard++;
    end
    chk("pre_rst_digit", 16'(bus.digit), 16'd2);
    rst_n = 1'b0;
    step();
    chk("mid_rst_h", 16'(bus.H), 16'hF);
    chk("mid_rst_l", 16'(bus.L), 16'h7F);
    chk("mid_rst_digit", 16'(bus.digit), 16'd0);
    rst_n = 1'b1;
    k = 0;
    step();
    chk("restart_h", 16'(bus.H), 16'b0111);
    chk("restart_l", 16'(bus.L), 16'b1000000);
    for (int i = 0; i < 8; i++) begin
      step();
      check_edge("restart");
    end

    repeat (1000) begin
      bus.Num = 16'($urandom);
      step();
      check_edge("rand");
      chk("rand_onehot", 16'($countones(~bus.H)), 16'd1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
